stopwatch_bcd_counter: RTL and testbench
========================================

# stopwatch_bcd_counter

- Eight-digit BCD time-of-stopwatch counter: HH:MM:SS:CC.
- Advances one centisecond per 100 Hz tick from the clock divider.
- Its packed 32-bit value feeds the lap memory write port and the display mux.
- A load port resumes counting from a stored lap value read back through the mux.

## Interface
Parameters:
- HOUR_MAX, 99: highest hours value, as a binary integer in the range 1..99.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high; sampled on rising clk edge.
- tc_cnt  in  1  one-cycle 100 Hz tick from the clock divider; held low while paused.
- clr  in  1  synchronous clear of time to zero.
- ld  in  1  synchronous load of ld_data.
- ld_data  in  32  packed BCD time to load; same layout as data.
- data  out  32  packed BCD time, registered.
- sec_pulse  out  1  one-cycle pulse on each seconds increment.
- ovf  out  1  sticky flag, set when the count passes HOUR_MAX:59:59.99.

## Operation
- data layout, MSB to LSB:
  - [31:28] hour tens, [27:24] hour units
  - [23:20] minute tens (0–5), [19:16] minute units
  - [15:12] second tens (0–5), [11:8] second units
  - [7:4] centisecond tens, [3:0] centisecond units
- Priority per cycle: reset > clr > ld > tc_cnt.
- reset: data=0, sec_pulse=0, ovf=0.
- clr: data=0, ovf=0, sec_pulse=0.
- ld: data=sanitised ld_data, ovf=0, sec_pulse=0. The tc_cnt pulse in the same cycle is discarded.
- Sanitising is per digit:
  - A unit digit greater than 9 becomes 0.
  - A minute-tens or second-tens digit greater than 5 becomes 0.
  - Hours above HOUR_MAX become 00.
- tc_cnt=1 with no higher-priority input: increment by one centisecond using a ripple carry chain, all in one cycle.
  - Each unit digit wraps 9→0 and carries into its tens digit.
  - Centiseconds wrap at 99 and carry into seconds.
  - Seconds and minutes each wrap at 59 and carry into the next field.
  - Hours wrap from HOUR_MAX to 00 and raise terminal carry.
- sec_pulse=1 exactly in the cycle after an increment whose centisecond field wrapped 99→00. At all other times sec_pulse=0.
- Terminal carry behaviour is described under Configuration.
- With tc_cnt low, data holds its value. This is the pause behaviour.

## Timing
- All outputs are registered. data, sec_pulse and ovf reflect an input sampled at edge N starting after edge N, i.e. one-cycle latency.
- No combinational path exists from any input to any output.
- tc_cnt high for k consecutive cycles produces k increments. The counter does not detect edges.
- After reset deassertion, counting may begin on the first tc_cnt.
- Reset mid-count: data returns to 0 on the next edge regardless of tc_cnt, ld or clr.
- clr and ld asserted together: clr wins.
- ovf stays high until reset, clr or ld.

## Configuration
- STOPWATCH_SATURATE_EN defined:
  - At HOUR_MAX:59:59.99, a tick leaves data unchanged, sets ovf=1 and produces no sec_pulse.
  - Further ticks keep data saturated.
- STOPWATCH_SATURATE_EN undefined:
  - The same tick wraps data to 00:00:00.00, sets ovf=1 and produces sec_pulse=1.
  - Counting continues normally afterwards.

## Test plan
- Reset, then 100 single tc_cnt pulses spaced 3 cycles apart -> data=32'h0000_0100, exactly one sec_pulse, coincident with data reaching 0x100.
- ld with ld_data=32'h0059_5999, then one tick -> data=32'h0100_0000, sec_pulse=1, ovf=0.
- ld with ld_data=32'h9959_5999, then one tick:
  - Macro defined -> data unchanged, ovf=1, sec_pulse=0.
  - Macro undefined -> data=0, ovf=1, sec_pulse=1.
- ld with ld_data=32'hAB6C_7F3E -> data=32'h0000_0030. Hours AB invalid -> 00; minute tens 6 -> 0 and unit C -> 0; second tens 7 -> 0 and unit F -> 0; cc 3E -> 30.
- Simultaneous events:
  - clr+ld+tc_cnt in one cycle -> data=0.
  - ld+tc_cnt with ld_data=32'h0000_1234 -> data=32'h0000_1234, no increment.
  - reset asserted while tc_cnt is high -> data=0, ovf=0.
- tc_cnt held high for 250 cycles from 0 -> data=32'h0000_0250, sec_pulse seen twice; tc_cnt low for 20 cycles -> data stable.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// Eight-digit BCD stopwatch counter HH:MM:SS:CC with load, clear and overflow flag.
// Define STOPWATCH_SATURATE_EN to hold at HOUR_MAX:59:59.99 instead of wrapping.
module stopwatch_bcd_counter #(
    parameter int unsigned HOUR_MAX = 99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tc_cnt,
    input  logic        clr,
    input  logic        ld,
    input  logic [31:0] ld_data,
    output logic [31:0] data,
    output logic        sec_pulse,
    output logic        ovf
);

    localparam logic [7:0] HMAX = 8'(HOUR_MAX);

    logic [31:0] data_q, data_d;
    logic        sec_q, sec_d;
    logic        ovf_q, ovf_d;
    logic [31:0] ld_clean;
    logic [31:0] inc_val;
    logic        cc_wrap;
    logic        term;
    logic        c;
    logic [3:0]  ld_hu;
    logic [7:0]  ld_hval;
    logic [7:0]  h_now;

    function automatic logic [3:0] fix(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? 4'd0 : d;
    endfunction

    // Returns {carry_out, digit}; digit wraps to 0 once it reaches lim.
    function automatic logic [4:0] bump(input logic [3:0] d, input logic [3:0] lim,
                                        input logic cin);
        if (!cin)
            return {1'b0, d};
        if (d >= lim)
            return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

    always_comb begin
        ld_clean[3:0]   = fix(ld_data[3:0], 4'd9);
        ld_clean[7:4]   = fix(ld_data[7:4], 4'd9);
        ld_clean[11:8]  = fix(ld_data[11:8], 4'd9);
        ld_clean[15:12] = fix(ld_data[15:12], 4'd5);
        ld_clean[19:16] = fix(ld_data[19:16], 4'd9);
        ld_clean[23:20] = fix(ld_data[23:20], 4'd5);
        ld_hu   = fix(ld_data[27:24], 4'd9);
        ld_hval = {4'd0, ld_data[31:28]} * 8'd10 + {4'd0, ld_hu};
        if (ld_data[31:28] <= 4'd9 && ld_hval <= HMAX)
            ld_clean[31:24] = {ld_data[31:28], ld_hu};
        else
            ld_clean[31:24] = 8'h00;
    end

    always_comb begin
        inc_val = data_q;
        term    = 1'b0;
        c       = 1'b1;
        h_now   = {4'd0, data_q[31:28]} * 8'd10 + {4'd0, data_q[27:24]};
        {c, inc_val[3:0]}   = bump(data_q[3:0], 4'd9, c);
        {c, inc_val[7:4]}   = bump(data_q[7:4], 4'd9, c);
        cc_wrap = c;
        {c, inc_val[11:8]}  = bump(data_q[11:8], 4'd9, c);
        {c, inc_val[15:12]} = bump(data_q[15:12], 4'd5, c);
        {c, inc_val[19:16]} = bump(data_q[19:16], 4'd9, c);
        {c, inc_val[23:20]} = bump(data_q[23:20], 4'd5, c);
        if (c && h_now >= HMAX) begin
            inc_val[31:24] = 8'h00;
            term = 1'b1;
        end else begin
            {c, inc_val[27:24]} = bump(data_q[27:24], 4'd9, c);
            {c, inc_val[31:28]} = bump(data_q[31:28], 4'd9, c);
        end
    end

    always_comb begin
        data_d = data_q;
        sec_d  = 1'b0;
        ovf_d  = ovf_q;
        if (clr) begin
            data_d = 32'd0;
            ovf_d  = 1'b0;
        end else if (ld) begin
            data_d = ld_clean;
            ovf_d  = 1'b0;
        end else if (tc_cnt) begin
            if (term) begin
`ifdef STOPWATCH_SATURATE_EN
                ovf_d  = 1'b1;
`else
                data_d = inc_val;
                sec_d  = 1'b1;
                ovf_d  = 1'b1;
`endif
            end else begin
                data_d = inc_val;
                sec_d  = cc_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= 32'd0;
            sec_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            sec_q  <= sec_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data      = data_q;
    assign sec_pulse = sec_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench for stopwatch_bcd_counter; model counts total centiseconds.
// Honours STOPWATCH_SATURATE_EN for the terminal-count expectations.
module tb_stopwatch_bcd_counter;

    localparam int unsigned HM    = 99;
    localparam int unsigned MAXCS = (HM * 3600 + 3599) * 100 + 99;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tc_cnt = 1'b0;
    logic        clr = 1'b0;
    logic        ld = 1'b0;
    logic [31:0] ld_data = 32'd0;
    logic [31:0] data;
    logic        sec_pulse;
    logic        ovf;

    stopwatch_bcd_counter #(.HOUR_MAX(HM)) dut (
        .clk(clk), .reset(reset), .tc_cnt(tc_cnt), .clr(clr), .ld(ld),
        .ld_data(ld_data), .data(data), .sec_pulse(sec_pulse), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sec_seen = 0;
    logic [33:0] exp_q[$];

    int unsigned m_cs = 0;
    bit m_sp = 0;
    bit m_ov = 0;

    function automatic int unsigned dig(logic [31:0] v, int i);
        return int'((v >> (4 * i)) & 32'hF);
    endfunction

    function automatic int unsigned to_cs(logic [31:0] v);
        int unsigned cc, s, m, h, ht, hu;
        cc = (dig(v, 1) > 9 ? 0 : dig(v, 1)) * 10 + (dig(v, 0) > 9 ? 0 : dig(v, 0));
        s  = (dig(v, 3) > 5 ? 0 : dig(v, 3)) * 10 + (dig(v, 2) > 9 ? 0 : dig(v, 2));
        m  = (dig(v, 5) > 5 ? 0 : dig(v, 5)) * 10 + (dig(v, 4) > 9 ? 0 : dig(v, 4));
        ht = dig(v, 7);
        hu = dig(v, 6) > 9 ? 0 : dig(v, 6);
        h  = ht * 10 + hu;
        if (ht > 9 || h > HM) h = 0;
        return ((h * 60 + m) * 60 + s) * 100 + cc;
    endfunction

    function automatic logic [31:0] to_bcd(int unsigned cs);
        int unsigned cc, s, m, h;
        cc = cs % 100;
        s  = (cs / 100) % 60;
        m  = (cs / 6000) % 60;
        h  = cs / 360000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic step(input logic r, input logic c, input logic l,
                        input logic [31:0] d, input logic t);
        @(negedge clk);
        reset = r; clr = c; ld = l; ld_data = d; tc_cnt = t;
        if (r || c) begin
            m_cs = 0; m_sp = 0; m_ov = 0;
        end else if (l) begin
            m_cs = to_cs(d); m_sp = 0; m_ov = 0;
        end else if (t) begin
            if (m_cs == MAXCS) begin
                m_ov = 1;
`ifdef STOPWATCH_SATURATE_EN
                m_sp = 0;
`else
                m_sp = 1;
                m_cs = 0;
`endif
            end else begin
                m_sp = (m_cs % 100 == 99);
                m_cs = m_cs + 1;
            end
        end else begin
            m_sp = 0;
        end
        exp_q.push_back({to_bcd(m_cs), m_sp, m_ov});
    endtask

    task automatic idle();
        step(0, 0, 0, 32'd0, 0);
    endtask

    task automatic tick();
        step(0, 0, 0, 32'd0, 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [33:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({data, sec_pulse, ovf} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got data=%h sp=%b ovf=%b want data=%h sp=%b ovf=%b",
                             $time, data, sec_pulse, ovf, e[33:2], e[1], e[0]);
                end
                if (sec_pulse === 1'b1) sec_seen++;
            end
        end
    end

    initial begin : stim
        int base;
        logic [31:0] pick;
        repeat (3) step(1, 0, 0, 32'd0, 1);
        idle();
        chk("reset_data", data, 32'd0);
        chk("reset_sp_ovf", {30'd0, sec_pulse, ovf}, 32'd0);

        base = sec_seen;
        for (int i = 0; i < 100; i++) begin
            tick(); idle(); idle();
        end
        idle();
        chk("100_ticks", data, 32'h0000_0100);
        chk("100_ticks_secp", 32'(sec_seen - base), 32'd1);

        step(0, 0, 1, 32'h0059_5999, 0);
        tick(); idle();
        chk("min_carry", data, 32'h0100_0000);
        chk("min_carry_flags", {30'd0, sec_pulse, ovf}, 32'b10);

        step(0, 0, 1, 32'h9959_5999, 0);
        tick(); idle();
`ifdef STOPWATCH_SATURATE_EN
        chk("term", data, 32'h9959_5999);
        chk("term_flags", {30'd0, sec_pulse, ovf}, 32'b01);
        tick(); idle();
        chk("term_hold", data, 32'h9959_5999);
`else
        chk("term", data, 32'h0000_0000);
        chk("term_flags", {30'd0, sec_pulse, ovf}, 32'b11);
        tick(); idle();
        chk("term_next", data, 32'h0000_0001);
`endif
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        step(0, 0, 1, 32'hAB6C_7F3E, 0);
        idle();
        chk("sanitise", data, 32'h0000_0030);

        step(0, 0, 1, 32'h1234_5678, 0);
        step(0, 1, 1, 32'h0000_4321, 1);
        idle();
        chk("clr_ld_tc", data, 32'd0);

        step(0, 0, 1, 32'h0000_1234, 1);
        idle();
        chk("ld_tc", data, 32'h0000_1234);

        step(0, 0, 1, 32'h9959_5999, 0);
        tick();
        step(1, 0, 0, 32'd0, 1);
        idle();
        chk("reset_mid", {data[30:0], ovf}, 32'd0);

        step(0, 1, 0, 32'd0, 0);
        base = sec_seen;
        repeat (250) tick();
        idle();
        chk("run250", data, 32'h0000_0250);
        chk("run250_secp", 32'(sec_seen - base), 32'd2);
        repeat (20) idle();
        chk("pause", data, 32'h0000_0250);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 4))
                0: pick = 32'h9959_5999;
                1: pick = 32'h9959_5990;
                2: pick = 32'h0959_5997;
                3: pick = 32'h0000_5995;
                default: pick = $urandom;
            endcase
            if (r < 1)       step(1, 0, 0, pick, r[0]);
            else if (r < 3)  step(0, 1, $urandom_range(0, 1) == 1, pick, 1);
            else if (r < 9)  step(0, 0, 1, pick, $urandom_range(0, 1) == 1);
            else if (r < 80) tick();
            else             idle();
        end

        idle();
        repeat (4) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
